kf8259_in_service: RTL and testbench



---
 rtl/kf8259_common_pkg.sv | 24 ++
 rtl/kf8259_priority_select.sv | 21 ++
 rtl/kf8259_in_service.sv | 56 +++++
 tb/tb_kf8259_in_service.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/kf8259_common_pkg.sv
// Shared KF8259 definitions: level count and the rotate/resolve helpers used by
// both the in-service stage and the interrupt-request priority resolver.
package kf8259_common_pkg;

  localparam int unsigned KF8259_LEVELS = 8;

  function automatic logic [7:0] rotate_right(input logic [7:0] data, input logic [2:0] n);
    logic [15:0] t;
    t = {data, data} >> n;
    return t[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] data, input logic [2:0] n);
    logic [15:0] t;
    t = {data, data} << n;
    return t[15:8];
  endfunction

  // One-hot of the lowest set bit; zero in gives zero out.
  function automatic logic [7:0] resolv_priority(input logic [7:0] data);
    return data & (~data + 8'd1);
  endfunction

endpackage

// File: rtl/kf8259_priority_select.sv
// Rotating-priority selector: picks the highest-priority set bit of request,
// where level (priority_rotate + 1) mod 8 is highest and priority_rotate lowest.
module kf8259_priority_select
  import kf8259_common_pkg::*;
(
  input  logic [2:0] priority_rotate,
  input  logic [7:0] request,
  output logic [7:0] selected
);

  logic [2:0] shift;
  logic [7:0] rotated;
  logic [7:0] resolved;

  // 3-bit add wraps rotate=7 to a zero shift, giving fixed IR0-first order.
  assign shift    = priority_rotate + 3'd1;
  assign rotated  = rotate_right(request, shift);
  assign resolved = resolv_priority(rotated);
  assign selected = rotate_left(resolved, shift);

endmodule

// File: rtl/kf8259_in_service.sv
// KF8259 In-Service Register stage: latches acknowledged levels, clears on EOI,
// and registers the highest-priority in-service level. Optional KF8259_SPECIAL_MASK_EN.
module kf8259_in_service
  import kf8259_common_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] priority_rotate,
  input  logic [7:0] interrupt,
  input  logic       latch_in_service,
  input  logic [7:0] end_of_interrupt,
`ifdef KF8259_SPECIAL_MASK_EN
  input  logic [7:0] interrupt_special_mask,
`endif
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service
);

  logic [7:0] isr_q, isr_d;
  logic [7:0] highest_q, highest_d;
  logic [7:0] search;

  always_comb begin
    isr_d = isr_q & ~end_of_interrupt;
    if (latch_in_service) begin
      isr_d = isr_d | interrupt;
    end
  end

  // Resolution runs on the next-state image so both outputs move on the same edge.
`ifdef KF8259_SPECIAL_MASK_EN
  assign search = isr_d & ~interrupt_special_mask;
`else
  assign search = isr_d;
`endif

  kf8259_priority_select u_select (
    .priority_rotate (priority_rotate),
    .request         (search),
    .selected        (highest_d)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      isr_q     <= '0;
      highest_q <= '0;
    end else begin
      isr_q     <= isr_d;
      highest_q <= highest_d;
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = highest_q;

endmodule

// File: tb/tb_kf8259_in_service.sv
// Scoreboard bench for kf8259_in_service: stimulus pushes hand-computed
// expectations, a monitor pops and checks them after each rising edge.
module tb_kf8259_in_service;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] priority_rotate = 3'd7;
  logic [7:0] interrupt = '0;
  logic       latch_in_service = 1'b0;
  logic [7:0] end_of_interrupt = '0;
`ifdef KF8259_SPECIAL_MASK_EN
  logic [7:0] interrupt_special_mask = '0;
`endif
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    string      name;
    logic [7:0] isr;
    logic [7:0] hi;
  } exp_t;

  exp_t sb_q[$];

  kf8259_in_service dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .priority_rotate          (priority_rotate),
    .interrupt                (interrupt),
    .latch_in_service         (latch_in_service),
    .end_of_interrupt         (end_of_interrupt),
`ifdef KF8259_SPECIAL_MASK_EN
    .interrupt_special_mask   (interrupt_special_mask),
`endif
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act_isr, input logic [7:0] act_hi,
                       input logic [7:0] exp_isr, input logic [7:0] exp_hi);
    checks++;
    if (act_isr !== exp_isr || act_hi !== exp_hi) begin
      errors++;
      $display("FAIL %s: isr=%h hi=%h, required isr=%h hi=%h", name, act_isr, act_hi, exp_isr, exp_hi);
    end
  endtask

  // Monitor: outputs are presented every edge; each pushed expectation covers one edge.
  always @(posedge clock) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.name, in_service_register, highest_level_in_service, e.isr, e.hi);
    end
  end

  task automatic step(input string name, input logic lat, input logic [7:0] intr,
                      input logic [7:0] eoi, input logic [2:0] rot,
                      input logic [7:0] exp_isr, input logic [7:0] exp_hi);
    @(negedge clock);
    latch_in_service = lat;
    interrupt        = intr;
    end_of_interrupt = eoi;
    priority_rotate  = rot;
    sb_q.push_back('{name, exp_isr, exp_hi});
  endtask

  task automatic reset_midcycle(input string name);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check({name, "_async"}, in_service_register, highest_level_in_service, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock);
      #1;
      check({name, "_hold"}, in_service_register, highest_level_in_service, 8'h00, 8'h00);
    end
    @(negedge clock);
    latch_in_service = 1'b0;
    interrupt        = '0;
    end_of_interrupt = '0;
    reset_n          = 1'b1;
  endtask

  initial begin
    // Reset: set a level then pull reset mid-cycle.
    @(negedge clock);
    reset_n = 1'b1;
    latch_in_service = 1'b1;
    interrupt = 8'h04;
    reset_midcycle("reset_first");
    step("idle_after_reset", 0, 8'h00, 8'h00, 3'd7, 8'h00, 8'h00);

    // Fixed priority
    step("latch_08", 1, 8'h08, 8'h00, 3'd7, 8'h08, 8'h08);
    step("latch_02", 1, 8'h02, 8'h00, 3'd7, 8'h0A, 8'h02);
    step("eoi_02",   0, 8'h00, 8'h02, 3'd7, 8'h08, 8'h08);
    step("eoi_08",   0, 8'h00, 8'h08, 3'd7, 8'h00, 8'h00);

    // Rotation
    step("latch_81_rot7", 1, 8'h81, 8'h00, 3'd7, 8'h81, 8'h01);
    step("rot0",          0, 8'h00, 8'h00, 3'd0, 8'h81, 8'h80);
    step("rot7",          0, 8'h00, 8'h00, 3'd7, 8'h81, 8'h01);
    step("rot3",          0, 8'h00, 8'h00, 3'd3, 8'h81, 8'h80);
    step("eoi_ff_a",      0, 8'h00, 8'hFF, 3'd7, 8'h00, 8'h00);

    // Simultaneous set/clear, EOI on clear bit, idempotent latch
    step("latch_10",      1, 8'h10, 8'h00, 3'd7, 8'h10, 8'h10);
    step("set_clr_10",    1, 8'h10, 8'h10, 3'd7, 8'h10, 8'h10);
    step("eoi_20_noop",   0, 8'h00, 8'h20, 3'd7, 8'h10, 8'h10);
    step("relatch_10",    1, 8'h10, 8'h00, 3'd7, 8'h10, 8'h10);
    step("eoi_00_noop",   0, 8'h00, 8'h00, 3'd7, 8'h10, 8'h10);
    step("eoi_10",        0, 8'h00, 8'h10, 3'd7, 8'h00, 8'h00);

    // Full / empty
    step("fill_0", 1, 8'h01, 8'h00, 3'd7, 8'h01, 8'h01);
    step("fill_1", 1, 8'h02, 8'h00, 3'd7, 8'h03, 8'h01);
    step("fill_2", 1, 8'h04, 8'h00, 3'd7, 8'h07, 8'h01);
    step("fill_3", 1, 8'h08, 8'h00, 3'd7, 8'h0F, 8'h01);
    step("fill_4", 1, 8'h10, 8'h00, 3'd7, 8'h1F, 8'h01);
    step("fill_5", 1, 8'h20, 8'h00, 3'd7, 8'h3F, 8'h01);
    step("fill_6", 1, 8'h40, 8'h00, 3'd7, 8'h7F, 8'h01);
    step("fill_7", 1, 8'h80, 8'h00, 3'd7, 8'hFF, 8'h01);
    step("full_rot5", 0, 8'h00, 8'h00, 3'd5, 8'hFF, 8'h40);
    step("full_rot6", 0, 8'h00, 8'h00, 3'd6, 8'hFF, 8'h80);
    step("eoi_ff_b",  0, 8'h00, 8'hFF, 3'd7, 8'h00, 8'h00);

    // Non-one-hot interrupt ORs all bits in
    step("latch_24",    1, 8'h24, 8'h00, 3'd7, 8'h24, 8'h04);
    step("eoi_04",      0, 8'h00, 8'h04, 3'd7, 8'h20, 8'h20);
    step("eoi_20",      0, 8'h00, 8'h20, 3'd7, 8'h00, 8'h00);

`ifdef KF8259_SPECIAL_MASK_EN
    @(negedge clock);
    interrupt_special_mask = 8'h02;
    step("smm_latch_06", 1, 8'h06, 8'h00, 3'd7, 8'h06, 8'h04);
    step("smm_hold",     0, 8'h00, 8'h00, 3'd7, 8'h06, 8'h04);
    @(negedge clock);
    interrupt_special_mask = 8'h00;
    step("smm_clear",    0, 8'h00, 8'h00, 3'd7, 8'h06, 8'h02);
    step("smm_eoi",      0, 8'h00, 8'h06, 3'd7, 8'h00, 8'h00);
`endif

    // Reset mid-service, then confirm nothing lingers after release
    step("latch_0c",    1, 8'h0C, 8'h00, 3'd7, 8'h0C, 8'h04);
    @(negedge clock);
    latch_in_service = 1'b0;
    interrupt = '0;
    while (sb_q.size() > 0) @(posedge clock);
    reset_midcycle("reset_mid_service");
    step("idle_post_reset", 0, 8'h00, 8'h00, 3'd7, 8'h00, 8'h00);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clock);
    @(posedge clock);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
